// File: rtl/return_addr_stack.sv
// Speculative return-address stack with a committed shadow copy.
// Predicted calls push fch_pc_r + RET_OFFSET. Predicted returns pop and supply the target.
// Writeback maintains the committed copy. Recovery reloads the speculative copy from it.
module return_addr_stack #(
    parameter int unsigned RAS_SIZE   = 3,
    parameter logic [2:0]  TYPE_CALL  = 3'd4,
    parameter logic [2:0]  TYPE_RET   = 3'd5,
    parameter logic [31:0] RET_OFFSET = 32'd4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                bpu_flush,
    input  logic                fch_valid_r,
    input  logic [31:0]         fch_pc_r,
    input  logic                bc_hit,
    input  logic [2:0]          bc_pred_type,
    input  logic                wrb_update_bpu,
    input  logic [31:0]         wrb_pc,
    input  logic [2:0]          wrb_branch_type,
    input  logic                wrb_restore,
    output logic                ras_pred_valid,
    output logic [31:0]         ras_pred_target,
    output logic [RAS_SIZE:0]   ras_count
);

    localparam int unsigned DEPTH  = 2 ** RAS_SIZE;
    localparam int unsigned PTR_W  = RAS_SIZE;
    localparam int unsigned CNT_W  = RAS_SIZE + 1;
    localparam int unsigned ADDR_W = 32;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Speculative stack state
    logic [ADDR_W-1:0] spec_stack_q [DEPTH];
    logic [ADDR_W-1:0] spec_stack_d [DEPTH];
    logic [PTR_W-1:0]  spec_tos_q, spec_tos_d;
    logic [CNT_W-1:0]  spec_cnt_q, spec_cnt_d;

    // Committed stack state
    logic [ADDR_W-1:0] com_stack_q [DEPTH];
    logic [ADDR_W-1:0] com_stack_d [DEPTH];
    logic [PTR_W-1:0]  com_tos_q, com_tos_d;
    logic [CNT_W-1:0]  com_cnt_q, com_cnt_d;

    logic              f_call_c;
    logic              f_ret_c;
    logic              w_call_c;
    logic              w_ret_c;
    logic [PTR_W-1:0]  spec_push_tos_c;
    logic [PTR_W-1:0]  com_push_tos_c;
    logic [ADDR_W-1:0] spec_push_addr_c;
    logic [ADDR_W-1:0] com_push_addr_c;

    // Decode fetch-side prediction and writeback-side resolution
    always_comb begin
        f_call_c = fch_valid_r & bc_hit & (bc_pred_type == TYPE_CALL);
        f_ret_c  = fch_valid_r & bc_hit & (bc_pred_type == TYPE_RET);
        w_call_c = wrb_update_bpu & (wrb_branch_type == TYPE_CALL);
        w_ret_c  = wrb_update_bpu & (wrb_branch_type == TYPE_RET);
    end

    // Push slot and return address for each stack
    always_comb begin
        spec_push_tos_c  = spec_tos_q + PTR_ONE;
        com_push_tos_c   = com_tos_q + PTR_ONE;
        spec_push_addr_c = fch_pc_r + RET_OFFSET;
        com_push_addr_c  = wrb_pc + RET_OFFSET;
    end

    // Committed next state: flush wins over the writeback update.
    // A full push wraps and overwrites the oldest entry.
    always_comb begin
        com_stack_d = com_stack_q;
        com_tos_d   = com_tos_q;
        com_cnt_d   = com_cnt_q;
        if (bpu_flush) begin
            com_tos_d = '0;
            com_cnt_d = '0;
        end else if (w_call_c) begin
            com_tos_d                  = com_push_tos_c;
            com_stack_d[com_push_tos_c] = com_push_addr_c;
            com_cnt_d                  = (com_cnt_q == CNT_FULL) ? CNT_FULL : com_cnt_q + CNT_ONE;
        end else if (w_ret_c && (com_cnt_q != '0)) begin
            com_tos_d = com_tos_q - PTR_ONE;
            com_cnt_d = com_cnt_q - CNT_ONE;
        end
    end

    // Speculative next state: flush, then restore from committed next state, then push, then pop
    always_comb begin
        spec_stack_d = spec_stack_q;
        spec_tos_d   = spec_tos_q;
        spec_cnt_d   = spec_cnt_q;
        if (bpu_flush) begin
            spec_tos_d = '0;
            spec_cnt_d = '0;
        end else if (wrb_restore) begin
            spec_stack_d = com_stack_d;
            spec_tos_d   = com_tos_d;
            spec_cnt_d   = com_cnt_d;
        end else if (f_call_c) begin
            spec_tos_d                    = spec_push_tos_c;
            spec_stack_d[spec_push_tos_c] = spec_push_addr_c;
            spec_cnt_d                    = (spec_cnt_q == CNT_FULL) ? CNT_FULL : spec_cnt_q + CNT_ONE;
        end else if (f_ret_c && (spec_cnt_q != '0)) begin
            spec_tos_d = spec_tos_q - PTR_ONE;
            spec_cnt_d = spec_cnt_q - CNT_ONE;
        end
    end

    // State registers for both stacks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                spec_stack_q[i] <= '0;
                com_stack_q[i]  <= '0;
            end
            spec_tos_q <= '0;
            spec_cnt_q <= '0;
            com_tos_q  <= '0;
            com_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                spec_stack_q[i] <= spec_stack_d[i];
                com_stack_q[i]  <= com_stack_d[i];
            end
            spec_tos_q <= spec_tos_d;
            spec_cnt_q <= spec_cnt_d;
            com_tos_q  <= com_tos_d;
            com_cnt_q  <= com_cnt_d;
        end
    end

    // Zero-latency prediction outputs
    always_comb begin
        ras_pred_valid  = f_ret_c & (spec_cnt_q != '0);
        ras_pred_target = spec_stack_q[spec_tos_q];
        ras_count       = spec_cnt_q;
    end

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack with hand-computed expectations.
module tb_return_addr_stack;

    localparam logic [2:0] T_CALL = 3'd4;
    localparam logic [2:0] T_RET  = 3'd5;
    localparam logic [2:0] T_OTH  = 3'd2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bpu_flush;
    logic        fch_valid_r;
    logic [31:0] fch_pc_r;
    logic        bc_hit;
    logic [2:0]  bc_pred_type;
    logic        wrb_update_bpu;
    logic [31:0] wrb_pc;
    logic [2:0]  wrb_branch_type;
    logic        wrb_restore;
    logic        ras_pred_valid;
    logic [31:0] ras_pred_target;
    logic [3:0]  ras_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    return_addr_stack dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .bpu_flush       (bpu_flush),
        .fch_valid_r     (fch_valid_r),
        .fch_pc_r        (fch_pc_r),
        .bc_hit          (bc_hit),
        .bc_pred_type    (bc_pred_type),
        .wrb_update_bpu  (wrb_update_bpu),
        .wrb_pc          (wrb_pc),
        .wrb_branch_type (wrb_branch_type),
        .wrb_restore     (wrb_restore),
        .ras_pred_valid  (ras_pred_valid),
        .ras_pred_target (ras_pred_target),
        .ras_count       (ras_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bpu_flush       = 1'b0;
        fch_valid_r     = 1'b0;
        fch_pc_r        = '0;
        bc_hit          = 1'b0;
        bc_pred_type    = '0;
        wrb_update_bpu  = 1'b0;
        wrb_pc          = '0;
        wrb_branch_type = '0;
        wrb_restore     = 1'b0;
    endtask

    task automatic set_fetch(input logic v, input logic [2:0] t, input logic [31:0] pc);
        fch_valid_r  = v;
        bc_hit       = 1'b1;
        bc_pred_type = t;
        fch_pc_r     = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_call(input logic [31:0] pc);
        set_fetch(1'b1, T_CALL, pc);
        tick();
        idle();
    endtask

    task automatic do_ret(input string tag, input logic exp_valid, input logic [31:0] exp_tgt);
        set_fetch(1'b1, T_RET, 32'h0);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(ras_pred_valid), 32'(exp_valid));
        if (exp_valid) check_eq({tag, "_target"}, ras_pred_target, exp_tgt);
        tick();
        idle();
    endtask

    task automatic check_count(input string tag, input int exp);
        @(negedge clk);
        check_eq(tag, 32'(ras_count), 32'(exp));
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        set_fetch(1'b1, T_RET, 32'h0);
        #3;
        check_eq("rst_valid", 32'(ras_pred_valid), 32'h0);
        check_eq("rst_target", ras_pred_target, 32'h0);
        check_eq("rst_count", 32'(ras_count), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        tick();

        // Single call / return
        do_call(32'h100);
        check_count("t1_count_after_call", 1);
        @(posedge clk); #1;
        do_ret("t1_ret", 1'b1, 32'h104);
        check_count("t1_count_after_ret", 0);
        @(posedge clk); #1;

        // Non-call/ret type and invalid fetch do nothing
        set_fetch(1'b1, T_OTH, 32'h180);
        tick();
        idle();
        check_count("other_type_count", 0);
        @(posedge clk); #1;

        // Nesting
        do_call(32'h100);
        do_call(32'h200);
        do_call(32'h300);
        check_count("t2_count", 3);
        @(posedge clk); #1;
        set_fetch(1'b0, T_RET, 32'h0);
        @(negedge clk);
        check_eq("t2_invalid_fetch_valid", 32'(ras_pred_valid), 32'h0);
        tick();
        idle();
        check_count("t2_invalid_fetch_count", 3);
        @(posedge clk); #1;
        do_ret("t2_ret0", 1'b1, 32'h304);
        do_ret("t2_ret1", 1'b1, 32'h204);
        do_ret("t2_ret2", 1'b1, 32'h104);
        do_ret("t2_ret3", 1'b0, 32'h0);
        check_count("t2_count_empty", 0);
        @(posedge clk); #1;

        // Overflow wraps and drops the oldest entry
        for (int k = 0; k < 9; k++) do_call(32'h1000 + 32'(k) * 32'h10);
        check_count("t3_count_full", 8);
        @(posedge clk); #1;
        for (int k = 8; k >= 1; k--) do_ret($sformatf("t3_ret%0d", k), 1'b1, 32'h1004 + 32'(k) * 32'h10);
        do_ret("t3_ret_empty", 1'b0, 32'h0);
        check_count("t3_count_empty", 0);
        @(posedge clk); #1;

        // Recovery from committed stack
        wrb_update_bpu  = 1'b1;
        wrb_branch_type = T_CALL;
        wrb_pc          = 32'h400;
        tick();
        idle();
        check_count("t4_wb_no_spec_effect", 0);
        @(posedge clk); #1;
        do_call(32'h500);
        do_call(32'h600);
        check_count("t4_spec_count", 2);
        @(posedge clk); #1;
        wrb_update_bpu  = 1'b1;
        wrb_branch_type = T_CALL;
        wrb_pc          = 32'h700;
        wrb_restore     = 1'b1;
        set_fetch(1'b1, T_CALL, 32'h900);
        tick();
        idle();
        check_count("t4_restore_count", 2);
        @(posedge clk); #1;
        do_ret("t4_ret0", 1'b1, 32'h704);
        do_ret("t4_ret1", 1'b1, 32'h404);
        do_ret("t4_ret2", 1'b0, 32'h0);

        // Flush beats restore and fetch push; committed stack also cleared
        do_call(32'h800);
        bpu_flush       = 1'b1;
        wrb_restore     = 1'b1;
        wrb_update_bpu  = 1'b1;
        wrb_branch_type = T_CALL;
        wrb_pc          = 32'h880;
        set_fetch(1'b1, T_CALL, 32'h990);
        tick();
        idle();
        check_count("t5_flush_count", 0);
        @(posedge clk); #1;
        do_ret("t5_ret", 1'b0, 32'h0);
        wrb_restore = 1'b1;
        tick();
        idle();
        check_count("t5_com_cleared", 0);
        @(posedge clk); #1;

        // Asynchronous reset between edges
        do_call(32'hA00);
        do_call(32'hB00);
        do_call(32'hC00);
        check_count("t6_count_pre", 3);
        set_fetch(1'b1, T_RET, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_async_count", 32'(ras_count), 32'h0);
        check_eq("t6_async_valid", 32'(ras_pred_valid), 32'h0);
        check_eq("t6_async_target", ras_pred_target, 32'h0);
        #1;
        reset_n = 1'b1;
        idle();
        tick();
        check_count("t6_post_count", 0);
        @(posedge clk); #1;
        do_call(32'h100);
        do_ret("t6_post_ret", 1'b1, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Speculative return-address stack (RAS) in the branch prediction unit, directly downstream of the branch cache.
- Uses the branch cache hit, type and current fetch PC:
  - pushes a return address on predicted calls;
  - pops and supplies a predicted return target on predicted returns.
- Keeps a committed copy, updated from writeback, which is copied into the speculative stack on misprediction recovery.

Parameters:
RAS_SIZE, 3, log2(number of stack entries); depth D = 2^RAS_SIZE
TYPE_CALL, 3'd4, branch-type code meaning call (jal/jalr with rd=x1/x5)
TYPE_RET, 3'd5, branch-type code meaning return (jalr rs1=x1/x5)
RET_OFFSET, 4, byte offset added to call PC to form return address

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
bpu_flush  in  1  clear both stacks
fch_valid_r  in  1  valid fetch this cycle
fch_pc_r  in  32  current fetch PC
bc_hit  in  1  branch cache hit for fch_pc_r
bc_pred_type  in  3  predicted branch type from branch cache
wrb_update_bpu  in  1  writeback reports a branch outcome
wrb_pc  in  32  PC of resolving instruction
wrb_branch_type  in  3  actual branch type
wrb_restore  in  1  misprediction: reload speculative stack from committed stack
ras_pred_valid  out  1  ras_pred_target is a valid return prediction this cycle
ras_pred_target  out  32  predicted return address
ras_count  out  RAS_SIZE+1  speculative occupancy, 0..D

Behaviour:
- State:
  - spec_stack[D] and com_stack[D], each 32-bit.
  - spec_tos and com_tos, RAS_SIZE-bit.
  - spec_cnt and com_cnt, RAS_SIZE+1-bit.
  - All state is registers (no RAM), so a full-stack copy takes one cycle.
- Reset (reset_n=0, async): all entries, tos and cnt = 0 → ras_pred_valid=0, ras_pred_target=0, ras_count=0.
- Fetch decode (combinational, same cycle as bc_hit):
  - f_call = fch_valid_r & bc_hit & (bc_pred_type==TYPE_CALL)
  - f_ret = fch_valid_r & bc_hit & (bc_pred_type==TYPE_RET)
- Outputs (combinational, zero latency):
  - ras_pred_valid = f_ret & (spec_cnt!=0)
  - ras_pred_target = spec_stack[spec_tos]
  - ras_count = spec_cnt
- Push (rising edge):
  - tos ← tos+1 mod D; entry[tos+1] ← pc+RET_OFFSET (32-bit wrap).
  - cnt ← min(cnt+1, D).
  - When full, the oldest entry is overwritten.
- Pop (rising edge):
  - If cnt>0: tos ← tos−1 mod D, cnt ← cnt−1.
  - If cnt==0: no state change.
- Committed stack, on wrb_update_bpu:
  - wrb_branch_type==TYPE_CALL → push wrb_pc+RET_OFFSET.
  - wrb_branch_type==TYPE_RET → pop.
  - Otherwise no change.
  - com_next denotes the committed state after this cycle's update.
- Speculative stack next-state priority:
  1. bpu_flush: both stacks' tos/cnt ← 0 (entries may keep their contents).
  2. wrb_restore: spec stack, tos and cnt ← com_next (includes the restoring instruction's own update); fetch push/pop this cycle ignored.
  3. f_call: spec push fch_pc_r+RET_OFFSET.
  4. f_ret: spec pop.
- Committed stack priority: bpu_flush over writeback update.
- f_call and f_ret are mutually exclusive by construction; the type field is a single code.
- Writeback never pushes or pops more than once per cycle. No throughput stall: one operation per stack per cycle.
- Deassertion of reset_n mid-operation: first edge after release behaves from the empty state.

Test Plan:
- Reset then call/return: f_call at fch_pc_r=0x100 → next cycle ras_count=1. Then f_ret → ras_pred_valid=1, ras_pred_target=0x104 that cycle; ras_count=0 after the edge.
- Nesting: calls at 0x100, 0x200, 0x300, then three returns → targets 0x304, 0x204, 0x104 in order. A fourth return → ras_pred_valid=0, ras_count stays 0.
- Overflow (D=8): 9 calls at PCs 0x1000+0x10·k, k=0..8 → ras_count=8. Returns yield 0x1084 down to 0x1014; then ras_pred_valid=0 (0x1004 overwritten).
- Recovery:
  - Setup: commit a call at 0x400 via writeback, then speculatively push 0x500 and 0x600.
  - Stimulus: assert wrb_restore with wrb_update_bpu=1, wrb_branch_type=TYPE_CALL, wrb_pc=0x700, plus a simultaneous f_call.
  - Required: ras_count=2 and a subsequent return predicts 0x704, then 0x404. The simultaneous fetch push is dropped.
- Flush priority: bpu_flush together with wrb_restore and f_call → both counts 0 next cycle; f_ret gives ras_pred_valid=0.
- Async reset mid-stream: reset_n pulsed low between clock edges with ras_count=3 → outputs 0 immediately, before the next edge.
